tff_counter: RTL and testbench
==============================

Name: tff_counter

Overview:
- Parametrised modulo-N up/down counter whose state is held entirely in a bank of T flip-flop cells; the successor to the single-bit toggle flop.
- Each cycle it computes a toggle vector (current ^ next) and drives the cells with it.
- Adds enable, direction, synchronous clear/load, modulus wrap or saturate, and terminal-count/wrap flags.
- Used as the general event/timebase counter in the same clock domain as the toggle-flop logic.

Parameters:
- WIDTH, 8, counter width in bits (>= 1).
- MODULUS, 256, count range 0..MODULUS-1; legal range 2 <= MODULUS <= 2**WIDTH.
- SATURATE, 0, 0 = wrap at the range ends; 1 = hold at the range ends.

Ports:
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous, active-low reset.
- en  in  1  count enable.
- up  in  1  direction: 1 = increment, 0 = decrement.
- clear  in  1  synchronous clear to 0.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  value to load.
- q  out  WIDTH  current count, registered.
- tc  out  1  terminal count, combinational from q and up.
- wrap_pulse  out  1  registered one-cycle pulse on wrap.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low on rstn.
  - rstn low forces q=0 and wrap_pulse=0 immediately, with no clock needed, including mid-count.
  - Release is sampled on the next rising clk edge; the first count happens at the first edge after release with en=1.
- Priority per rising edge: clear > load > en. Otherwise q holds (toggle vector all zero).
- clear=1: q <= 0 and wrap_pulse <= 0, regardless of load, en or up.
- load=1 (clear=0):
  - q <= load_val if load_val <= MODULUS-1, otherwise q <= MODULUS-1 (clamp).
  - wrap_pulse <= 0.
  - en is ignored that cycle.
- en=1, up=1:
  - q < MODULUS-1: q <= q+1.
  - q == MODULUS-1: wrap mode gives q <= 0 and wrap_pulse <= 1; saturate mode holds q with wrap_pulse <= 0.
- en=1, up=0:
  - q > 0: q <= q-1.
  - q == 0: wrap mode gives q <= MODULUS-1 and wrap_pulse <= 1; saturate mode holds q with wrap_pulse <= 0.
- wrap_pulse:
  - High exactly one cycle, in the cycle after the wrapping edge (coincident with the new q).
  - Cleared on every edge where no wrap occurs.
- tc = (up & q==MODULUS-1) | (~up & q==0). Independent of en and SATURATE.
- Next-value arithmetic:
  - Done at WIDTH+1 bits so that MODULUS = 2**WIDTH wraps correctly.
  - Result truncated to WIDTH.
  - No X propagation from load_val unless load=1.
- State storage:
  - Every bit of q is an instance of the per-bit cell below.
  - Cell input t[i] = q[i] ^ next[i].
  - No other register holds count state. wrap_pulse is a separate plain flop with the same async reset.
- Out-of-range q cannot occur: reset, clear and clamped load keep q within 0..MODULUS-1.
- Parameter check: elaboration-time error if MODULUS < 2 or MODULUS > 2**WIDTH.

Decomposition:
- Shared package: none required; parameters are local.
- Sub-module tff_cell: ports clk, rstn, t, q.
  - q toggles on a rising clk edge when t=1.
  - Async active-low reset to 0.
  - Instantiated WIDTH times via generate.
- Top-level tff_counter holds the next-value/priority logic, the clamp, tc, and the wrap_pulse flop.

Test Plan:
All scenarios use WIDTH=4, MODULUS=10 unless stated; clk period 10 ns.
1. rstn=0 for 40 ns with en=1 -> q=0 and wrap_pulse=0 throughout; release rstn with en=0 for 40 ns -> q stays 0, tc=1 with up=1 is false, tc=1 with up=0 is true.
2. rstn=1, en=1, up=1 from 0 for 10 edges -> q steps 1..9 then 0; tc=1 only while q=9; wrap_pulse=1 for exactly the one cycle with q=0.
3. en=1, up=0 from q=0 -> q=9 with a single-cycle wrap_pulse; the next 3 edges give q=8, 7, 6.
4. SATURATE=1, count up from 7 for 5 edges -> q=8, 9, 9, 9, 9; wrap_pulse never asserts. Counting down from 1 saturates at 0.
5. Load and clear:
   - load=1, load_val=7, en=1 -> q=7 next edge.
   - load_val=12 -> q=9 (clamp).
   - clear=1 with load=1 -> q=0.
   - WIDTH=4, MODULUS=16: counting up from 15 -> q=0 with wrap_pulse.
6. Count up to q=5, then drop rstn between clock edges -> q=0 before the next rising edge; after release, counting resumes 1, 2, ...

Source files
------------

// File: rtl/tff_cell.sv
`default_nettype none
// ============================================================================
// Module      : tff_cell
// Description : Single T flip-flop storage cell. Toggles on a rising clock
//               edge when t is high; asynchronous active-low reset to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_cell (
    input  logic clk,
    input  logic rstn,
    input  logic t,
    output logic q
);

    // Toggle storage bit when t is asserted; reset clears without a clock.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tff_counter.sv
`default_nettype none
// ============================================================================
// Module      : tff_counter
// Description : Modulo-N up/down counter whose count lives entirely in a bank
//               of T flip-flop cells. Supports enable, direction, synchronous
//               clear/load (with clamp), wrap or saturate at range ends, a
//               combinational terminal-count flag and a registered wrap pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tff_counter #(
    parameter int WIDTH    = 8,
    parameter int MODULUS  = 256,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             up,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap_pulse
);

    // Arithmetic is carried one bit wider so MODULUS == 2**WIDTH still has a
    // representable maximum and comparisons never overflow.
    localparam logic [WIDTH:0]   C_MAX_EXT = (WIDTH+1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] C_MAX     = WIDTH'(MODULUS - 1);

    // Reject illegal modulus values at elaboration.
    if (MODULUS < 2 || (WIDTH < 31 && MODULUS > (1 << WIDTH))) begin : g_param_check
        $error("tff_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH:0]   cnt_ext_d;
    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] toggle_d;
    logic             wrap_d;
    logic             wrap_q;
    logic             w_unused_msb;
    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_lv_ext;

    assign w_cnt_ext = {1'b0, cnt_q};
    assign w_lv_ext  = {1'b0, load_val};

    // Next count and wrap decision: clear beats load beats enable, else hold.
    always_comb begin
        cnt_ext_d = w_cnt_ext;
        wrap_d    = 1'b0;
        if (clear) begin
            cnt_ext_d = '0;
        end else if (load) begin
            cnt_ext_d = (w_lv_ext > C_MAX_EXT) ? C_MAX_EXT : w_lv_ext;
        end else if (en) begin
            if (up) begin
                if (w_cnt_ext == C_MAX_EXT) begin
                    if (!SATURATE) begin
                        cnt_ext_d = '0;
                        wrap_d    = 1'b1;
                    end
                end else begin
                    cnt_ext_d = w_cnt_ext + 1'b1;
                end
            end else begin
                if (w_cnt_ext == '0) begin
                    if (!SATURATE) begin
                        cnt_ext_d = C_MAX_EXT;
                        wrap_d    = 1'b1;
                    end
                end else begin
                    cnt_ext_d = w_cnt_ext - 1'b1;
                end
            end
        end
    end

    // The extra arithmetic bit is always zero after range limiting.
    assign cnt_d        = cnt_ext_d[WIDTH-1:0];
    assign w_unused_msb = cnt_ext_d[WIDTH];

    // Cells only need to know which bits change.
    assign toggle_d = cnt_q ^ cnt_d;

    // One T flip-flop per count bit holds the entire counter state.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cells
        tff_cell u_cell (
            .clk  (clk),
            .rstn (rstn),
            .t    (toggle_d[i]),
            .q    (cnt_q[i])
        );
    end

    // Wrap pulse register: high for exactly the cycle after a wrapping edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign q          = cnt_q;
    assign wrap_pulse = wrap_q;
    assign tc         = (up & (cnt_q == C_MAX)) | (~up & (cnt_q == '0));

endmodule
`default_nettype wire

// File: tb/tb_tff_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tff_counter
// Description : Self-checking bench for tff_counter. Three instances:
//               0 = WIDTH 4 / MODULUS 10 wrap, 1 = same with saturate,
//               2 = WIDTH 4 / MODULUS 16 wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tff_counter;

    logic       clk;
    logic       rstn;
    logic       en   [3];
    logic       up   [3];
    logic       clr  [3];
    logic       ld   [3];
    logic [3:0] lv   [3];
    logic [3:0] q    [3];
    logic       tc   [3];
    logic       wp   [3];

    int checks;
    int errors;

    typedef struct {
        logic       clr;
        logic       ld;
        logic [3:0] lv;
        logic       en;
        logic       up;
        logic [3:0] eq;
        logic       etc;
        logic       ewp;
    } vec_t;

    vec_t tbl[$];

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_dut0 (
        .clk(clk), .rstn(rstn), .en(en[0]), .up(up[0]), .clear(clr[0]),
        .load(ld[0]), .load_val(lv[0]), .q(q[0]), .tc(tc[0]), .wrap_pulse(wp[0])
    );

    tff_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_dut1 (
        .clk(clk), .rstn(rstn), .en(en[1]), .up(up[1]), .clear(clr[1]),
        .load(ld[1]), .load_val(lv[1]), .q(q[1]), .tc(tc[1]), .wrap_pulse(wp[1])
    );

    tff_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_dut2 (
        .clk(clk), .rstn(rstn), .en(en[2]), .up(up[2]), .clear(clr[2]),
        .load(ld[2]), .load_val(lv[2]), .q(q[2]), .tc(tc[2]), .wrap_pulse(wp[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Set one instance's controls (others idle) just after a falling edge,
    // then return 1 ns after the following rising edge.
    task automatic drive(input int d, input logic c, input logic l,
                         input logic [3:0] v, input logic e, input logic u);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; clr[k] = 1'b0; ld[k] = 1'b0; lv[k] = 4'd0;
        end
        clr[d] = c; ld[d] = l; lv[d] = v; en[d] = e; up[d] = u;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string name, input int d,
                           input int eq, input int etc, input int ewp);
        chk({name, ".q"},  int'(q[d]),  eq);
        chk({name, ".tc"}, int'(tc[d]), etc);
        chk({name, ".wp"}, int'(wp[d]), ewp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            en[k] = 1'b0; up[k] = 1'b1; clr[k] = 1'b0; ld[k] = 1'b0; lv[k] = 4'd0;
        end
        en[0] = 1'b1;

        // Up count from 0: 1..9 then wrap to 0.
        for (int i = 1; i <= 10; i++)
            tbl.push_back('{1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 4'(i % 10),
                            (i == 9) ? 1'b1 : 1'b0, (i == 10) ? 1'b1 : 1'b0});
        // Down from 0: wrap to 9, then 8, 7, 6.
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd9, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd8, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd7, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd6, 1'b0, 1'b0});
        // Load, clamp, clear priority, hold.
        tbl.push_back('{1'b0, 1'b1, 4'd7,  1'b1, 1'b1, 4'd7, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd12, 1'b1, 1'b1, 4'd9, 1'b1, 1'b0});
        tbl.push_back('{1'b1, 1'b1, 4'd5,  1'b1, 1'b1, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b0, 1'b1, 4'd0, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd9, 1'b0, 1'b1});
        tbl.push_back('{1'b0, 1'b1, 4'd3,  1'b1, 1'b0, 4'd3, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b0, 4'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 4'd2, 1'b0, 1'b0});
        tbl.push_back('{1'b0, 1'b1, 4'd9,  1'b1, 1'b1, 4'd9, 1'b1, 1'b0});
        tbl.push_back('{1'b0, 1'b0, 4'd0,  1'b1, 1'b1, 4'd0, 1'b0, 1'b1});
        tbl.push_back('{1'b1, 1'b0, 4'd0,  1'b1, 1'b0, 4'd0, 1'b1, 1'b0});

        // Held in reset with en=1: nothing moves.
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("rst.q",  int'(q[0]),  0);
            chk("rst.wp", int'(wp[0]), 0);
        end
        @(negedge clk);
        rstn  = 1'b1;
        en[0] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("idle.q", int'(q[0]), 0);
        end
        up[0] = 1'b1;
        #1;
        chk("idle.tc_up", int'(tc[0]), 0);
        up[0] = 1'b0;
        #1;
        chk("idle.tc_dn", int'(tc[0]), 1);

        // Table-driven sequence on the wrapping modulo-10 instance.
        foreach (tbl[i]) begin
            drive(0, tbl[i].clr, tbl[i].ld, tbl[i].lv, tbl[i].en, tbl[i].up);
            chk_out($sformatf("vec%0d", i), 0, int'(tbl[i].eq),
                    int'(tbl[i].etc), int'(tbl[i].ewp));
        end

        // Saturating instance: up from 7 sticks at 9, down from 1 sticks at 0.
        drive(1, 1'b0, 1'b1, 4'd7, 1'b0, 1'b1);
        chk_out("sat.ld7", 1, 7, 0, 0);
        drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk_out("sat.up1", 1, 8, 0, 0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
            chk_out("sat.up_hold", 1, 9, 1, 0);
        end
        drive(1, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
        chk_out("sat.ld1", 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
            chk_out("sat.dn_hold", 1, 0, 1, 0);
        end

        // Full-range modulus: 15 wraps to 0 and back.
        drive(2, 1'b0, 1'b1, 4'd15, 1'b0, 1'b1);
        chk_out("m16.ld15", 2, 15, 1, 0);
        drive(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk_out("m16.wrap_up", 2, 0, 0, 1);
        drive(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk_out("m16.up1", 2, 1, 0, 0);
        drive(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("m16.dn0", 2, 0, 1, 0);
        drive(2, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        chk_out("m16.wrap_dn", 2, 15, 0, 1);

        // Asynchronous reset mid-count, then resume.
        for (int i = 1; i <= 5; i++)
            drive(0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        chk("arst.pre", int'(q[0]), 5);
        #3;
        rstn = 1'b0;
        #1;
        chk("arst.async_q",  int'(q[0]),  0);
        chk("arst.async_wp", int'(wp[0]), 0);
        @(posedge clk);
        #1;
        chk("arst.held", int'(q[0]), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("arst.resume1", int'(q[0]), 1);
        @(posedge clk);
        #1;
        chk("arst.resume2", int'(q[0]), 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
